wts_channel_mixer: RTL and testbench

Time-multiplexed mixer directly downstream of the per-channel envelope/tone stages. It walks all channels once per frame, paced by the 3.579 MHz `active` pulse. For each channel it scales the signed wave-SRAM sample by that channel's 9-bit envelope and accumulates the channel products. Once per frame it emits one saturated 16-bit signed mix sample to the output/DAC stage.

---
 rtl/wts_pkg.sv | 13 +
 rtl/wts_mixer_mac.sv | 74 +++++++
 rtl/wts_channel_mixer.sv | 77 +++++++
 tb/tb_wts_channel_mixer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wts_pkg.sv
// rtl/wts_pkg.sv - shared widths and constants for the wavetable channel mixer
package wts_pkg;

    localparam int WTS_CH_NUM_DEFAULT = 6;

    localparam int WTS_SAMPLE_W  = 8;
    localparam int WTS_ENV_W     = 9;
    localparam int WTS_PROD_W    = 18;
    localparam int WTS_ACC_W     = 21;
    localparam int WTS_OUT_W     = 16;
    localparam int WTS_OUT_SHIFT = 2;

endpackage

// File: rtl/wts_mixer_mac.sv
// rtl/wts_mixer_mac.sv - multiply/accumulate stages and 16-bit output reduction
// WTS_MIXER_SATURATION_EN selects clamping; otherwise the output wraps.
module wts_mixer_mac
    import wts_pkg::*;
(
    input  logic                        clk,
    input  logic                        nreset,
    input  logic                        active_i,
    input  logic [WTS_SAMPLE_W-1:0]     sram_q_i,
    input  logic [WTS_ENV_W-1:0]        env_i,
    input  logic                        v1_i,
    input  logic                        first1_i,
    input  logic                        last1_i,
    output logic [WTS_OUT_W-1:0]        sample_out_o,
    output logic                        sample_valid_o
);

    logic signed [WTS_PROD_W-1:0] sample_ext, env_ext, prod_d, prod_q;
    logic signed [WTS_ACC_W-1:0]  prod_acc, acc_sum, acc_q;
    logic                         v2_q, first2_q, last2_q;
    logic [WTS_OUT_W-1:0]         reduced;
    logic [WTS_OUT_W-1:0]         sample_out_q;
    logic                         sample_valid_q;

    // Envelope is zero-extended so values above 255 still act as positive gain
    assign sample_ext = {{(WTS_PROD_W-WTS_SAMPLE_W){sram_q_i[WTS_SAMPLE_W-1]}}, sram_q_i};
    assign env_ext    = {{(WTS_PROD_W-WTS_ENV_W){1'b0}}, env_i};
    assign prod_d     = sample_ext * env_ext;

    assign prod_acc = {{(WTS_ACC_W-WTS_PROD_W){prod_q[WTS_PROD_W-1]}}, prod_q};
    assign acc_sum  = first2_q ? prod_acc : acc_q + prod_acc;

`ifdef WTS_MIXER_SATURATION_EN
    logic signed [WTS_ACC_W-1:0] mix;
    assign mix = acc_sum >>> WTS_OUT_SHIFT;
    always_comb begin
        reduced = mix[WTS_OUT_W-1:0];
        if (mix > 21'sd32767)
            reduced = 16'h7fff;
        else if (mix < -21'sd32768)
            reduced = 16'h8000;
    end
`else
    assign reduced = acc_sum[WTS_OUT_SHIFT +: WTS_OUT_W];
`endif

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            prod_q         <= '0;
            v2_q           <= 1'b0;
            first2_q       <= 1'b0;
            last2_q        <= 1'b0;
            acc_q          <= '0;
            sample_out_q   <= '0;
            sample_valid_q <= 1'b0;
        end else begin
            sample_valid_q <= active_i & v2_q & last2_q;
            if (active_i) begin
                prod_q   <= prod_d;
                v2_q     <= v1_i;
                first2_q <= first1_i;
                last2_q  <= last1_i;
                if (v2_q)
                    acc_q <= acc_sum;
                if (v2_q && last2_q)
                    sample_out_q <= reduced;
            end
        end
    end

    assign sample_out_o   = sample_out_q;
    assign sample_valid_o = sample_valid_q;

endmodule

// File: rtl/wts_channel_mixer.sv
// rtl/wts_channel_mixer.sv - time-multiplexed channel mixer: slot sequencer and envelope stage
// Output reduction mode is chosen by WTS_MIXER_SATURATION_EN inside wts_mixer_mac.
module wts_channel_mixer
    import wts_pkg::*;
#(
    parameter int CH_NUM = WTS_CH_NUM_DEFAULT
) (
    input  logic                    clk,
    input  logic                    nreset,
    input  logic                    active,
    output logic [2:0]              ch_sel,
    input  logic [WTS_ENV_W-1:0]    ch_envelope,
    input  logic [WTS_SAMPLE_W-1:0] sram_q,
    input  logic [CH_NUM-1:0]       reg_ch_mute,
    output logic [WTS_OUT_W-1:0]    sample_out,
    output logic                    sample_valid
);

    localparam int SLOT_W = 4;
    localparam logic [SLOT_W-1:0] SLOT_LAST    = SLOT_W'(CH_NUM + 1);
    localparam logic [SLOT_W-1:0] SLOT_CH      = SLOT_W'(CH_NUM);
    localparam logic [SLOT_W-1:0] SLOT_LAST_CH = SLOT_W'(CH_NUM - 1);

    logic [SLOT_W-1:0]    slot_q, slot_d;
    logic [2:0]           ch_sel_q, ch_sel_d;
    logic [WTS_ENV_W-1:0] env_d1_q, env_d1_d;
    logic                 v1_q, v1_d, first1_q, first1_d, last1_q, last1_d;
    logic                 issue;

    // Two trailing slots per frame drain the multiply and accumulate stages
    assign issue = slot_q < SLOT_CH;

    always_comb begin
        slot_d   = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
        ch_sel_d = (slot_d < SLOT_CH) ? slot_d[2:0] : 3'd0;
        env_d1_d = env_d1_q;
        v1_d     = issue;
        first1_d = issue && (slot_q == '0);
        last1_d  = issue && (slot_q == SLOT_LAST_CH);
        if (issue)
            env_d1_d = reg_ch_mute[ch_sel_q] ? '0 : ch_envelope;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            slot_q   <= '0;
            ch_sel_q <= 3'd0;
            env_d1_q <= '0;
            v1_q     <= 1'b0;
            first1_q <= 1'b0;
            last1_q  <= 1'b0;
        end else if (active) begin
            slot_q   <= slot_d;
            ch_sel_q <= ch_sel_d;
            env_d1_q <= env_d1_d;
            v1_q     <= v1_d;
            first1_q <= first1_d;
            last1_q  <= last1_d;
        end
    end

    assign ch_sel = ch_sel_q;

    wts_mixer_mac u_mac (
        .clk            (clk),
        .nreset         (nreset),
        .active_i       (active),
        .sram_q_i       (sram_q),
        .env_i          (env_d1_q),
        .v1_i           (v1_q),
        .first1_i       (first1_q),
        .last1_i        (last1_q),
        .sample_out_o   (sample_out),
        .sample_valid_o (sample_valid)
    );

endmodule

// File: tb/tb_wts_channel_mixer.sv
// tb/tb_wts_channel_mixer.sv - scoreboard bench for wts_channel_mixer against a frame-level mix model
module tb_wts_channel_mixer;

    localparam int CH    = 6;
    localparam int FRAME = CH + 2;

    logic          clk = 1'b0;
    logic          nreset;
    logic          active;
    logic [2:0]    ch_sel;
    logic [8:0]    ch_envelope;
    logic [7:0]    sram_q;
    logic [CH-1:0] reg_ch_mute;
    logic [15:0]   sample_out;
    logic          sample_valid;

    int         env_t [8];
    int         wave_t[8];
    logic [7:0] mute_t;
    logic [2:0] addr_lat;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] exp_q[$];
    int          mode  = 0;
    int          phase = 0;
    int          edges;
    int          slot_m;

    always #5 clk = ~clk;

    wts_channel_mixer #(.CH_NUM(CH)) dut (
        .clk          (clk),
        .nreset       (nreset),
        .active       (active),
        .ch_sel       (ch_sel),
        .ch_envelope  (ch_envelope),
        .sram_q       (sram_q),
        .reg_ch_mute  (reg_ch_mute),
        .sample_out   (sample_out),
        .sample_valid (sample_valid)
    );

    // Upstream model: envelope follows ch_sel directly, SRAM data appears one active edge after its address
    assign ch_envelope = 9'(env_t[ch_sel]);
    assign sram_q      = 8'(wave_t[addr_lat]);
    assign reg_ch_mute = mute_t[CH-1:0];

    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            addr_lat <= 3'd0;
            edges    <= 0;
            slot_m   <= 0;
        end else if (active) begin
            addr_lat <= ch_sel;
            edges    <= edges + 1;
            slot_m   <= (slot_m == FRAME - 1) ? 0 : slot_m + 1;
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model(input int e[8], input int w[8], input logic [7:0] m);
        longint sum = 0;
        longint mix;
        for (int k = 0; k < CH; k++)
            if (!m[k])
                sum += longint'(w[k]) * longint'(e[k]);
        mix = sum >>> 2;
`ifdef WTS_MIXER_SATURATION_EN
        if (mix > 32767)  mix = 32767;
        if (mix < -32768) mix = -32768;
`endif
        return 16'(mix);
    endfunction

    // Monitor: pops the scoreboard on each pulse and checks pulse shape and ch_sel sequence
    int   last_edge  = 0;
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        if (!nreset) begin
            last_edge  = 0;
            prev_valid = 1'b0;
        end else begin
            check("ch_sel", ch_sel, (slot_m < CH) ? slot_m : 0);
            if (sample_valid) begin
                check("pulse_width", prev_valid, 0);
                check("pulse_spacing", edges - last_edge, FRAME);
                last_edge = edges;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pulse: got sample %0d with empty scoreboard", $signed(sample_out));
                end else begin
                    check("sample_out", longint'($signed(sample_out)), longint'($signed(exp_q.pop_front())));
                end
            end
            prev_valid = sample_valid;
        end
    end

    task automatic tick();
        @(negedge clk);
        case (mode)
            0: active = 1'b1;
            1: begin
                active = (phase == 0);
                phase  = (phase + 1) % 3;
            end
            default: active = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic load(input int e[8], input int w[8], input logic [7:0] m);
        env_t  = e;
        wave_t = w;
        mute_t = m;
        exp_q.push_back(model(e, w, m));
    endtask

    task automatic wait_pulse();
        int n = 0;
        do begin
            tick();
            n++;
        end while (!sample_valid && n < 300);
        if (!sample_valid) begin
            total++;
            bad++;
            $display("FAIL pulse_timeout: got no sample_valid within %0d clks", n);
        end
    endtask

    task automatic rand_frame(output int e[8], output int w[8], output logic [7:0] m);
        for (int k = 0; k < 8; k++) begin
            e[k] = int'($urandom_range(0, 511));
            w[k] = int'($urandom_range(0, 255)) - 128;
        end
        m = 8'($urandom & $urandom & $urandom);
    endtask

    int         e[8];
    int         w[8];
    logic [7:0] m;
    int         n;

    initial begin
        nreset = 1'b0;
        active = 1'b0;
        mute_t = 8'h00;
        for (int k = 0; k < 8; k++) begin
            env_t[k]  = 0;
            wave_t[k] = 0;
        end
        repeat (3) @(negedge clk);
        check("reset_ch_sel", ch_sel, 0);
        check("reset_sample_out", sample_out, 0);
        check("reset_sample_valid", sample_valid, 0);

        // Channel 0 alone: 64 * 256 / 4 = 4096
        for (int k = 0; k < 8; k++) begin e[k] = 0; w[k] = 0; end
        e[0] = 256; w[0] = 64;
        load(e, w, 8'hFE);
        @(negedge clk);
        nreset = 1'b1;
        wait_pulse();
        load(e, w, 8'hFE);
        wait_pulse();

        // Full-scale positive and negative sums
        for (int k = 0; k < 8; k++) begin e[k] = 511; w[k] = 127; end
        load(e, w, 8'h00);
        wait_pulse();
        for (int k = 0; k < 8; k++) begin e[k] = 511; w[k] = -128; end
        load(e, w, 8'h00);
        wait_pulse();

        // Muted channel contributes nothing, then unmuted gives 300 * 10 / 4 = 750
        for (int k = 0; k < 8; k++) begin e[k] = 0; w[k] = 100; end
        e[3] = 300; w[3] = 10;
        load(e, w, 8'h08);
        wait_pulse();
        load(e, w, 8'h00);
        wait_pulse();

        // Same patterns with active pulsed one clk in three
        mode = 1;
        for (int k = 0; k < 8; k++) begin e[k] = 511; w[k] = 127; end
        load(e, w, 8'h00);
        wait_pulse();
        for (int k = 0; k < 8; k++) begin e[k] = 511; w[k] = -128; end
        load(e, w, 8'h00);
        wait_pulse();
        for (int i = 0; i < 4; i++) begin
            rand_frame(e, w, m);
            load(e, w, m);
            wait_pulse();
        end

        // Random active gaps with random frames
        mode = 2;
        for (int i = 0; i < 10; i++) begin
            rand_frame(e, w, m);
            load(e, w, m);
            wait_pulse();
        end

        // Reset in slot 3 discards the partial frame
        mode = 0;
        rand_frame(e, w, m);
        load(e, w, m);
        n = 0;
        while (slot_m != 3 && n < 50) begin
            tick();
            n++;
        end
        check("reached_slot3", slot_m, 3);
        nreset = 1'b0;
        #1;
        check("midreset_ch_sel", ch_sel, 0);
        check("midreset_sample_out", sample_out, 0);
        check("midreset_sample_valid", sample_valid, 0);
        exp_q.delete();
        exp_q.push_back(model(e, w, m));
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        wait_pulse();
        rand_frame(e, w, m);
        load(e, w, m);
        wait_pulse();

        repeat (4) tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
